// File: rtl/axi_top_16x16_pkg.sv
// Shared AXI constants and FSM state types for the 16x16 PIM tile host interface.
package axi_top_16x16_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi_top_16x16_mem.sv
// Dual word array: every write lands in both mem1 and mem2; reads come from mem1 through a register.
module axi_top_16x16_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_WIDTH  = 14
) (
  input  logic                  clock_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_WIDTH-1:0]  widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_WIDTH-1:0]  ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  logic [DATA_WIDTH-1:0] mem1 [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] mem2 [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock_i) begin
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (we_i && wstrb_i[b]) begin
        mem1[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        mem2[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // A read in the same cycle as a write to the same word sees the old contents.
  always_ff @(posedge clock_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem1[ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_top_16x16.sv
// AXI4 slave front end: independent write and read FSMs over the dual mem1/mem2 word array.
module axi_top_16x16
  import axi_top_16x16_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int VALID_ADDR_WIDTH = ADDR_WIDTH - LSB;

  // WRAP bursts are treated as INCR; the index wraps at the array size.
  function automatic logic [VALID_ADDR_WIDTH-1:0] next_idx(
    input logic [VALID_ADDR_WIDTH-1:0] idx, input logic [1:0] burst);
    case (burst)
      AXI_BURST_FIXED:                next_idx = idx;
      AXI_BURST_INCR, AXI_BURST_WRAP: next_idx = idx + 1'b1;
      default:                        next_idx = idx + 1'b1;
    endcase
  endfunction

  wstate_e wstate_q, wstate_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d, wid_q, wid_d;
  logic [VALID_ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0] wburst_q, wburst_d;

  rstate_e rstate_q, rstate_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [VALID_ADDR_WIDTH-1:0] ridx_q, ridx_d;
  logic [7:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0] rburst_q, rburst_d;

  logic aw_hs, w_hs, ar_hs, r_hs, mem_re;
  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid & wready_q;
  assign ar_hs = s_axi_arvalid & arready_q;
  assign r_hs  = rvalid_q & s_axi_rready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wstate_q <= W_IDLE;  awready_q <= 1'b0; wready_q <= 1'b0;
      bvalid_q <= 1'b0;    bid_q <= '0;       wcnt_q <= '0;
      rstate_q <= R_IDLE;  arready_q <= 1'b0; rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;    rid_q <= '0;       rcnt_q <= '0;
    end else begin
      wstate_q <= wstate_d; awready_q <= awready_d; wready_q <= wready_d;
      bvalid_q <= bvalid_d; bid_q <= bid_d;         wcnt_q <= wcnt_d;
      rstate_q <= rstate_d; arready_q <= arready_d; rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;  rid_q <= rid_d;         rcnt_q <= rcnt_d;
    end
    wid_q <= wid_d; widx_q <= widx_d; wlen_q <= wlen_d; wburst_q <= wburst_d;
    ridx_q <= ridx_d; rlen_q <= rlen_d; rburst_q <= rburst_d;
  end

  always_comb begin
    wstate_d = wstate_q; awready_d = awready_q; wready_d = wready_q;
    bvalid_d = bvalid_q; bid_d = bid_q; wid_d = wid_q; widx_d = widx_q;
    wlen_d = wlen_q; wburst_d = wburst_q; wcnt_d = wcnt_q;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = s_axi_awid;
          widx_d    = s_axi_awaddr[ADDR_WIDTH-1:LSB];
          wlen_d    = s_axi_awlen;
          wburst_d  = s_axi_awburst;
          wcnt_d    = '0;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (s_axi_wlast || (wcnt_q == wlen_q)) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = wid_q;
            wstate_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            widx_d = next_idx(widx_q, wburst_q);
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q; arready_d = arready_q; rvalid_d = rvalid_q;
    rlast_d = rlast_q; rid_d = rid_q; ridx_d = ridx_q;
    rlen_d = rlen_q; rburst_d = rburst_q; rcnt_d = rcnt_q;
    mem_re = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_axi_arid;
          rlast_d   = (s_axi_arlen == 8'd0);
          ridx_d    = s_axi_araddr[ADDR_WIDTH-1:LSB];
          rlen_d    = s_axi_arlen;
          rburst_d  = s_axi_arburst;
          rcnt_d    = '0;
          mem_re    = 1'b1;
          rstate_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            ridx_d  = next_idx(ridx_q, rburst_q);
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            mem_re  = 1'b1;
          end
        end
      end
    endcase
  end

  axi_top_16x16_mem #(
    .DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH), .IDX_WIDTH(VALID_ADDR_WIDTH)
  ) u_mem (
    .clock_i(clock), .rst_ni(reset),
    .we_i(w_hs & reset), .widx_i(widx_q), .wdata_i(s_axi_wdata), .wstrb_i(s_axi_wstrb),
    .re_i(mem_re), .ridx_i(ridx_d), .rdata_o(s_axi_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = AXI_RESP_OKAY;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = AXI_RESP_OKAY;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                           s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

endmodule

// File: tb/tb_axi_top_16x16.sv
// Directed and randomized single-beat checks of the AXI4 PIM tile front end against a shadow word model.
module tb_axi_top_16x16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  awid = '0, arid = '0, awlen = '0, arlen = '0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rlast, rvalid;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [16384];
  logic [31:0] wbuf [8];
  logic [31:0] rexp [8];
  logic [15:0] rnd_addr [100];

  always #5 clock = ~clock;

  axi_top_16x16 dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'b010),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'b010),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int bstall);
    int n;
    logic [13:0] idx;
    idx = addr[15:2];
    @(negedge clock);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) chk("aw_timeout", 32'd0, 32'd1);
    @(negedge clock);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb; wlast = (b == int'(len));
      n = 0;
      while (!wready && n < 20) begin @(negedge clock); n++; end
      if (n >= 20) chk("w_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[idx][k*8 +: 8] = wbuf[b][k*8 +: 8];
      if (burst != 2'b00) idx = idx + 14'd1;
      @(negedge clock);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) chk("b_timeout", 32'd0, 32'd1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 32'd0);
    chk("wready_low_in_resp", 32'(wready), 32'd0);
    repeat (bstall) begin
      @(negedge clock);
      chk("b_stall_valid", 32'(bvalid), 32'd1);
      chk("b_stall_id", 32'(bid), 32'(id));
    end
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    chk("b_done", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall);
    int n;
    logic [31:0] held;
    @(negedge clock);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clock); n++; end
    if (n >= 20) chk("ar_timeout", 32'd0, 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 20) begin @(negedge clock); n++; end
      if (n >= 20) begin
        chk("r_timeout", 32'd0, 32'd1);
        return;
      end
      if (b == 0 && stall > 0) begin
        held = rdata;
        repeat (stall) begin
          @(negedge clock);
          chk("r_stall_valid", 32'(rvalid), 32'd1);
          chk("r_stall_data", rdata, held);
        end
      end
      chk("rdata", rdata, rexp[b]);
      chk("rid", 32'(rid), 32'(id));
      chk("rlast", 32'(rlast), (b == int'(len)) ? 32'd1 : 32'd0);
      chk("rresp", 32'(rresp), 32'd0);
      rready = 1'b1;
      @(negedge clock);
    end
    rready = 1'b0;
    chk("r_done", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int diffs;
    logic [13:0] ridx;
    for (int i = 0; i < 16384; i++) model[i] = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);
    diffs = 0;
    for (int i = 0; i < 16384; i++)
      if (dut.u_mem.mem1[i] !== 32'd0 || dut.u_mem.mem2[i] !== 32'd0) diffs++;
    chk("mem_init_zero", 32'(diffs), 32'd0);

    wbuf[0] = 32'hDEADBEEF;
    do_write(8'd3, 16'h0104, 8'd0, 2'b01, 4'hF, 0);
    chk("single_mem1", dut.u_mem.mem1[14'h41], 32'hDEADBEEF);
    chk("single_mem2", dut.u_mem.mem2[14'h41], 32'hDEADBEEF);
    rexp[0] = 32'hDEADBEEF;
    do_read(8'd5, 16'h0106, 8'd0, 2'b01, 0);

    wbuf[0] = 32'h11223344;
    do_write(8'd7, 16'h0104, 8'd0, 2'b01, 4'b0101, 0);
    rexp[0] = 32'hDE22BE44;
    do_read(8'd9, 16'h0104, 8'd0, 2'b01, 0);

    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
    do_write(8'hA5, 16'hFFF8, 8'd3, 2'b01, 4'hF, 3);
    chk("incr_3FFE", dut.u_mem.mem1[14'h3FFE], 32'd1);
    chk("incr_3FFF", dut.u_mem.mem1[14'h3FFF], 32'd2);
    chk("incr_0000", dut.u_mem.mem1[14'h0000], 32'd3);
    chk("incr_0001", dut.u_mem.mem2[14'h0001], 32'd4);
    rexp[0] = 32'd1; rexp[1] = 32'd2; rexp[2] = 32'd3; rexp[3] = 32'd4;
    do_read(8'h5A, 16'hFFF8, 8'd3, 2'b01, 5);

    wbuf[0] = 32'hAAAA0001; wbuf[1] = 32'hBBBB0002;
    do_write(8'd1, 16'h0200, 8'd1, 2'b00, 4'hF, 0);
    chk("fixed_0080", dut.u_mem.mem1[14'h0080], 32'hBBBB0002);
    chk("fixed_0081", dut.u_mem.mem1[14'h0081], 32'd0);

    for (int i = 0; i < 100; i++) begin
      rnd_addr[i] = 16'($urandom);
      wbuf[0] = $urandom;
      do_write(8'($urandom), rnd_addr[i], 8'd0, 2'b01, 4'hF, 0);
    end
    for (int i = 0; i < 100; i++) begin
      ridx = rnd_addr[i][15:2];
      rexp[0] = model[ridx];
      do_read(8'(i), rnd_addr[i], 8'd0, 2'b01, 0);
    end
    for (int i = 0; i < 10; i++) begin
      araddr = 16'($urandom);
      ridx = araddr[15:2];
      rexp[0] = model[ridx];
      do_read(8'hEE, araddr, 8'd0, 2'b01, 0);
    end

    diffs = 0;
    for (int i = 0; i < 16384; i++) if (dut.u_mem.mem1[i] !== model[i]) diffs++;
    chk("mem1_vs_model", 32'(diffs), 32'd0);
    diffs = 0;
    for (int i = 0; i < 16384; i++) if (dut.u_mem.mem2[i] !== dut.u_mem.mem1[i]) diffs++;
    chk("mem2_eq_mem1", 32'(diffs), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
